// File: rtl/dma_burst_chan.sv
// rtl/dma_burst_chan.sv - FIFO-buffered burst DMA channel between gstmcu RDY handshake and device streams (option: DMA_DONE_IRQ_EN)
module dma_burst_chan #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int BURST    = 8,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic           clk32,
    input  logic           resb,
    input  logic           clk_en,
    input  logic           FCS_N,
    input  logic           RW,
    input  logic           A1,
    input  logic [15:0]    DIN,
    output logic [15:0]    DOUT,
    input  logic           RDY_I,
    output logic           RDY_O,
    output logic [CHW-1:0] dev_chan,
    input  logic           dev_in_valid,
    output logic           dev_in_ready,
    input  logic [15:0]    dev_in_data,
    output logic           dev_out_valid,
    input  logic           dev_out_ready,
    output logic [15:0]    dev_out_data,
    output logic           INT_N
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [15:0] BURST_W = 16'(BURST);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_BURST, ST_DRAIN} state_t;

    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    level;
    logic           dir;
    logic [CHW-1:0] chan;
    logic [15:0]    cnt, icnt, burst_left;
    logic           err;
    logic           rdy_o_q;
    state_t         state;

    logic        reg_wr, flush, empty, full, strobe, xfer, bad;
    logic        in_hs, out_hs, push, pop, go;
    logic [15:0] head, need, level16, free16, status, mode_rd;
    logic        unused_bits;

    assign reg_wr  = clk_en && !FCS_N && !RW;
    // Count writes and FLUSH both discard buffered data.
    assign flush   = reg_wr && (!A1 || DIN[14]);
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign head    = mem[rd_ptr];
    assign strobe  = clk_en && !RDY_I && !reg_wr;
    assign xfer    = strobe && !rdy_o_q && (dir ? !full : !empty);
    assign bad     = strobe && !xfer;

    assign dev_in_ready  = !dir && (icnt != 16'd0) && !full;
    assign dev_out_valid = dir && !empty;
    assign dev_out_data  = empty ? 16'h0000 : head;
    assign in_hs         = dev_in_valid && dev_in_ready;
    assign out_hs        = dev_out_valid && dev_out_ready;
    assign push          = dir ? xfer : in_hs;
    assign pop           = dir ? out_hs : xfer;

    assign need    = (cnt < BURST_W) ? cnt : BURST_W;
    assign level16 = 16'(level);
    assign free16  = 16'(DEPTH_L - level);
    assign go      = (cnt != 16'd0) && (dir ? (free16 >= need) : (level16 >= need));

    assign status  = {cnt[7:0], 4'b0000, full, empty, cnt != 16'd0, err};
    assign mode_rd = {dir, 1'b0, {(14 - CHW){1'b0}}, chan};
    assign unused_bits = ^DIN[13:CHW];

    always_comb begin
        DOUT = empty ? 16'h0000 : head;
        if (!FCS_N && RW)
            DOUT = A1 ? mode_rd : status;
    end

    assign RDY_O    = rdy_o_q;
    assign dev_chan = chan;

    always_ff @(posedge clk32) begin
        if (resb && !flush && push)
            mem[wr_ptr] <= dir ? DIN : dev_in_data;
    end

    always_ff @(posedge clk32) begin
        if (!resb || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk32) begin
        if (!resb) begin
            dir        <= 1'b0;
            chan       <= '0;
            cnt        <= '0;
            icnt       <= '0;
            err        <= 1'b0;
            burst_left <= '0;
            rdy_o_q    <= 1'b1;
            state      <= ST_IDLE;
        end else if (reg_wr) begin
            if (A1) begin
                dir  <= DIN[15];
                chan <= DIN[CHW-1:0];
                if (DIN[14]) begin
                    cnt     <= '0;
                    icnt    <= '0;
                    rdy_o_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            end else begin
                cnt     <= DIN;
                icnt    <= DIN;
                err     <= 1'b0;
                rdy_o_q <= 1'b1;
                state   <= ST_IDLE;
            end
        end else begin
            if (bad)
                err <= 1'b1;
            if (in_hs && icnt != 16'd0)
                icnt <= icnt - 16'd1;
            case (state)
                ST_BURST: begin
                    if (xfer) begin
                        if (cnt != 16'd0)
                            cnt <= cnt - 16'd1;
                        burst_left <= burst_left - 16'd1;
                        // Release the request on the edge that takes the last word.
                        if (burst_left == 16'd1 || cnt == 16'd1) begin
                            rdy_o_q <= 1'b1;
                            state   <= ST_FILL;
                        end
                    end
                end
                default: begin
                    if (clk_en && go) begin
                        state      <= ST_BURST;
                        rdy_o_q    <= 1'b0;
                        burst_left <= need;
                    end else if (cnt != 16'd0)
                        state <= ST_FILL;
                    else if (!empty)
                        state <= ST_DRAIN;
                    else
                        state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMA_DONE_IRQ_EN
    logic int_n_q;

    always_ff @(posedge clk32) begin
        if (!resb)
            int_n_q <= 1'b1;
        else if (clk_en)
            int_n_q <= !(xfer && cnt == 16'd1);
    end

    assign INT_N = int_n_q;
`else
    assign INT_N = 1'b1;
`endif

endmodule

// File: tb/tb_dma_burst_chan.sv
// tb/tb_dma_burst_chan.sv - scoreboard bench for dma_burst_chan (DMA_DONE_IRQ_EN aware)
module tb_dma_burst_chan;
    localparam int BURST = 8;
`ifdef DMA_DONE_IRQ_EN
    localparam int IRQ_TICKS = 4;
`else
    localparam int IRQ_TICKS = 0;
`endif

    logic        clk32, resb, clk_en, FCS_N, RW, A1, RDY_I, RDY_O, INT_N;
    logic [15:0] DIN, DOUT, dev_in_data, dev_out_data;
    logic [0:0]  dev_chan;
    logic        dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ready;

    dma_burst_chan #(.CHANNELS(2), .DEPTH(8), .BURST(BURST)) dut (
        .clk32(clk32), .resb(resb), .clk_en(clk_en), .FCS_N(FCS_N), .RW(RW), .A1(A1),
        .DIN(DIN), .DOUT(DOUT), .RDY_I(RDY_I), .RDY_O(RDY_O), .dev_chan(dev_chan),
        .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready), .dev_in_data(dev_in_data),
        .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready), .dev_out_data(dev_out_data),
        .INT_N(INT_N)
    );

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    int          phase = 0, src_idx = 0, src_n = 0, bursts = 0, cur_len = 0, exp_len = 0;
    int          rem = 0, out_cnt = 0, irq_low = 0, b0 = 0;
    logic [15:0] src_base = 0, din_word = 0, wr_data = 0, rd;
    logic        pend_wr = 0, wr_a1 = 0, mcu_on = 0, spurious = 0, dir_m = 0, rdy_prev = 1;
    logic [0:0]  chan_m = 0;

    initial begin
        clk32 = 0;
        forever #5 clk32 = ~clk32;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [15:0] got);
        if (exp_q.size() == 0)
            check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        else
            check(tag, 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic tick();
        @(negedge clk32);
        phase   = (phase == 3) ? 0 : phase + 1;
        clk_en  = (phase == 3);
        if (rdy_prev && !RDY_O) begin
            bursts++;
            cur_len = 0;
            exp_len = (rem < BURST) ? rem : BURST;
        end
        if (!rdy_prev && RDY_O)
            check("burst_len", 32'(cur_len), 32'(exp_len));
        rdy_prev = RDY_O;
        if (!INT_N)
            irq_low++;
        RDY_I = 1; FCS_N = 1; RW = 0; A1 = 0;
        if (clk_en && pend_wr) begin
            FCS_N = 0; A1 = wr_a1; DIN = wr_data; pend_wr = 0;
        end else if (clk_en && mcu_on && !RDY_O) begin
            RDY_I = 0; cur_len++; rem--;
            if (!dir_m)
                sb_pop("dout", DOUT);
            else begin
                DIN = din_word;
                exp_q.push_back(din_word);
                din_word++;
            end
        end else if (clk_en && spurious) begin
            RDY_I = 0; spurious = 0;
        end
        dev_in_valid = (src_idx < src_n);
        dev_in_data  = src_base + 16'(src_idx);
        if (dev_in_valid && dev_in_ready) begin
            exp_q.push_back(dev_in_data);
            src_idx++;
        end
        if (dev_out_valid && dev_out_ready) begin
            sb_pop("dev_out", dev_out_data);
            check("dev_chan", 32'(dev_chan), 32'(chan_m));
            out_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reg_write(input logic a1, input logic [15:0] d);
        wr_a1 = a1; wr_data = d; pend_wr = 1;
        for (int i = 0; i < 16 && pend_wr; i++) tick();
        tick();
    endtask

    task automatic check_reg(input string tag, input logic a1, input logic [15:0] exp);
        FCS_N = 0; RW = 1; A1 = a1;
        #1;
        rd = DOUT;
        FCS_N = 1; RW = 0; A1 = 0;
        check(tag, 32'(rd), 32'(exp));
    endtask

    task automatic start_src(input logic [15:0] base, input int n);
        src_base = base; src_idx = 0; src_n = n;
    endtask

    task automatic wait_read_done(input string tag);
        int i;
        for (i = 0; i < 3000 && !(src_idx == src_n && exp_q.size() == 0 && RDY_O); i++) tick();
        check(tag, 32'(i < 3000), 32'd1);
    endtask

    initial begin
        resb = 0; clk_en = 0; FCS_N = 1; RW = 0; A1 = 0; DIN = 0; RDY_I = 1;
        dev_in_valid = 0; dev_in_data = 0; dev_out_ready = 1;
        ticks(4);
        check("rst_dout", 32'(DOUT), 32'h0);
        check("rst_rdy_o", 32'(RDY_O), 32'h1);
        check("rst_in_ready", 32'(dev_in_ready), 32'h0);
        check("rst_out_valid", 32'(dev_out_valid), 32'h0);
        check("rst_out_data", 32'(dev_out_data), 32'h0);
        check("rst_chan", 32'(dev_chan), 32'h0);
        check("rst_int_n", 32'(INT_N), 32'h1);
        resb = 1;
        tick();
        check_reg("rst_status", 1'b0, 16'h0004);
        check_reg("rst_mode", 1'b1, 16'h0000);

        // device->memory, two full bursts
        dir_m = 0; chan_m = 1;
        reg_write(1'b1, 16'h0001);
        check_reg("mode_rd", 1'b1, 16'h0001);
        reg_write(1'b0, 16'd16);
        check_reg("cnt_status", 1'b0, 16'h1006);
        b0 = bursts; rem = 16; mcu_on = 1;
        start_src(16'h1000, 16);
        wait_read_done("rd16_done");
        ticks(8);
        check("rd16_bursts", 32'(bursts - b0), 32'd2);
        check_reg("rd16_status", 1'b0, 16'h0004);

        // device stalls on a full FIFO while the MCU holds off
        mcu_on = 0;
        reg_write(1'b0, 16'd16);
        b0 = bursts; rem = 16;
        start_src(16'h2000, 16);
        ticks(200);
        check("stall_ready", 32'(dev_in_ready), 32'h0);
        check("stall_rdy_o", 32'(RDY_O), 32'h0);
        check("stall_accepted", 32'(src_idx), 32'd8);
        check_reg("stall_status", 1'b0, 16'h100A);
        mcu_on = 1;
        wait_read_done("stall_done");
        ticks(8);
        check("stall_bursts", 32'(bursts - b0), 32'd2);
        check_reg("stall_end_status", 1'b0, 16'h0004);

        // memory->device, one short burst
        dir_m = 1; chan_m = 1; din_word = 16'hA000; out_cnt = 0;
        reg_write(1'b1, 16'h8001);
        b0 = bursts; rem = 5;
        reg_write(1'b0, 16'd5);
        for (int i = 0; i < 2000 && !(out_cnt == 5 && RDY_O); i++) tick();
        ticks(20);
        check("wr_words", 32'(out_cnt), 32'd5);
        check("wr_bursts", 32'(bursts - b0), 32'd1);
        check("wr_chan", 32'(dev_chan), 32'h1);
        check("wr_sb_empty", 32'(exp_q.size()), 32'd0);
        check_reg("wr_status", 1'b0, 16'h0004);

        // spurious strobe outside a burst
        dir_m = 0; chan_m = 0;
        reg_write(1'b1, 16'h0000);
        reg_write(1'b0, 16'd4);
        start_src(16'h4000, 2);
        ticks(40);
        check_reg("spur_before", 1'b0, 16'h0402);
        spurious = 1;
        ticks(8);
        check_reg("spur_err", 1'b0, 16'h0403);
        src_n = 0; src_idx = 0;
        reg_write(1'b0, 16'd0);
        exp_q.delete();
        check_reg("spur_cleared", 1'b0, 16'h0004);

        // single-word completion drives the interrupt when enabled
        irq_low = 0; rem = 1; b0 = bursts;
        reg_write(1'b0, 16'd1);
        start_src(16'h3000, 1);
        wait_read_done("one_done");
        ticks(20);
        check("one_bursts", 32'(bursts - b0), 32'd1);
        check("irq_pulse", 32'(irq_low), 32'(IRQ_TICKS));

        // FLUSH clears count without an interrupt
        irq_low = 0;
        reg_write(1'b0, 16'd3);
        check_reg("flush_pre", 1'b0, 16'h0306);
        reg_write(1'b1, 16'h4001);
        ticks(12);
        check_reg("flush_mode", 1'b1, 16'h0001);
        check_reg("flush_status", 1'b0, 16'h0004);
        check("flush_irq", 32'(irq_low), 32'd0);

        // reset while a burst request is outstanding
        mcu_on = 0; chan_m = 1;
        reg_write(1'b0, 16'd8);
        rem = 8;
        start_src(16'h5000, 8);
        for (int i = 0; i < 200 && RDY_O; i++) tick();
        check("mid_rdy_low", 32'(RDY_O), 32'h0);
        resb = 0;
        rdy_prev = 1;
        tick();
        check("mid_rdy_o", 32'(RDY_O), 32'h1);
        resb = 1;
        src_n = 0; src_idx = 0;
        exp_q.delete();
        check_reg("mid_status", 1'b0, 16'h0004);
        check("mid_in_ready", 32'(dev_in_ready), 32'h0);
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
